sddt_cmd_arbiter: RTL and testbench

//  N-channel AXI-Stream command ingress for sddt_core: merges NUM_CH PS command streams into one.

---
 rtl/sddt_cmd_pkg.sv | 25 ++
 rtl/axis_skid_buf.sv | 54 +++++
 rtl/sddt_cmd_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_sddt_cmd_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sddt_cmd_pkg.sv
// Shared types and GPIO status-word layout for the sddt command ingress arbiter.
package sddt_cmd_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    localparam int GPIO_CNT_LSB   = 0;
    localparam int GPIO_CNT_W     = 16;
    localparam int GPIO_PEND_LSB  = 16;
    localparam int GPIO_PEND_W    = 8;
    localparam int GPIO_GNT_LSB   = 24;
    localparam int GPIO_GNT_W     = 3;
    localparam int GPIO_BUSY_BIT  = 27;
    localparam int GPIO_TRUNC_BIT = 28;
    localparam int GPIO_OVF_BIT   = 29;
    localparam int GPIO_STALL_BIT = 30;

    // Channel index width; a single channel still gets a 1-bit tuser.
    function automatic int ch_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry registered skid buffer: output is always a flop, 1 clk latency, 1 beat/clk sustained.
// up_rdy deasserts only when both entries are full; a stalled output holds its data.
module axis_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] up_dat,
    input  logic         up_vld,
    output logic         up_rdy,
    output logic [W-1:0] dn_dat,
    output logic         dn_vld,
    input  logic         dn_rdy,
    output logic         empty
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   cnt;
    logic         push;
    logic         pop;

    assign up_rdy = (cnt != 2'd2);
    assign dn_vld = (cnt != 2'd0);
    assign empty  = (cnt == 2'd0);
    assign dn_dat = mem[rd_ptr];
    assign push   = up_vld & up_rdy;
    assign pop    = dn_vld & dn_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= up_dat;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/sddt_cmd_arbiter.sv
// Merges NUM_CH AXI-Stream command channels round-robin, burst-locked on tlast, forced release after MAX_BURST beats.
// 1 clk from accepted beat to m_axis_tvalid; s_axis_tready tracks skid space; SDDT_CMD_CH_TAG_EN stamps the channel into tdata[DATA_W-1 -: 3].
module sddt_cmd_arbiter
    import sddt_cmd_pkg::*;
#(
    parameter  int NUM_CH    = 2,
    parameter  int DATA_W    = 128,
    parameter  int MAX_BURST = 16,
    parameter  int CNT_W     = 16,
    localparam int CH_W      = ch_width(NUM_CH)
) (
    input  logic                     axi_aclk,
    input  logic                     sys_rst,
    input  logic [NUM_CH*DATA_W-1:0] s_axis_tdata,
    input  logic [NUM_CH-1:0]        s_axis_tvalid,
    input  logic [NUM_CH-1:0]        s_axis_tlast,
    output logic [NUM_CH-1:0]        s_axis_tready,
    output logic [DATA_W-1:0]        m_axis_tdata,
    output logic                     m_axis_tvalid,
    output logic                     m_axis_tlast,
    output logic [CH_W-1:0]          m_axis_tuser,
    input  logic                     m_axis_tready,
    input  logic [NUM_CH-1:0]        ch_enable,
    input  logic                     clr_stats,
    output logic [31:0]              gpio_out
);

    localparam int               BC_W       = (MAX_BURST <= 1) ? 1 : $clog2(MAX_BURST);
    localparam int               PAY_W      = DATA_W + 1 + CH_W;
    localparam logic [BC_W-1:0]  BURST_LAST = BC_W'(MAX_BURST - 1);
    localparam logic [CNT_W-1:0] CNT_TOP    = '1;

    arb_state_e       state_q, state_d;
    logic [CH_W-1:0]  grant_q, grant_d;
    logic [CH_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [BC_W-1:0]  burst_q, burst_d;

    logic [NUM_CH-1:0] cand;
    logic [CH_W-1:0]   pick;
    logic [CH_W-1:0]   idx;
    logic              pick_vld;

    logic              sel_vld;
    logic              sel_last;
    logic [DATA_W-1:0] sel_dat;
    logic [DATA_W-1:0] tag_dat;
    logic              accept;
    logic              forced;

    logic              buf_rdy;
    logic              buf_empty;
    logic [PAY_W-1:0]  buf_in;
    logic [PAY_W-1:0]  buf_out;

    logic [CNT_W-1:0]  beat_cnt;
    logic              trunc;
    logic              ovf;
    logic              m_hs;

    assign cand     = s_axis_tvalid & ch_enable;
    assign sel_vld  = s_axis_tvalid[grant_q];
    assign sel_last = s_axis_tlast[grant_q];
    assign sel_dat  = s_axis_tdata[grant_q*DATA_W +: DATA_W];

    // Search starts one past the last served channel so every enabled requester gets a turn.
    always_comb begin
        pick     = rr_ptr_q;
        pick_vld = 1'b0;
        idx      = rr_ptr_q;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = (idx == CH_W'(NUM_CH - 1)) ? '0 : idx + 1'b1;
            if (!pick_vld && cand[idx]) begin
                pick     = idx;
                pick_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge axi_aclk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            burst_q  <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            burst_q  <= burst_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        rr_ptr_d      = rr_ptr_q;
        burst_d       = burst_q;
        s_axis_tready = '0;
        accept        = 1'b0;
        forced        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    grant_d = pick;
                    burst_d = '0;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                s_axis_tready[grant_q] = buf_rdy;
                accept = sel_vld & buf_rdy;
                if (accept) begin
                    if (sel_last || (burst_q == BURST_LAST)) begin
                        state_d  = ST_IDLE;
                        rr_ptr_d = grant_q;
                        forced   = ~sel_last;
                    end else begin
                        burst_d = burst_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tag_dat = sel_dat;
`ifdef SDDT_CMD_CH_TAG_EN
        tag_dat[DATA_W-1 -: 3] = 3'(grant_q);
`endif
    end

    assign buf_in = {tag_dat, sel_last | forced, grant_q};

    axis_skid_buf #(
        .W (PAY_W)
    ) u_skid (
        .clk    (axi_aclk),
        .rst    (sys_rst),
        .up_dat (buf_in),
        .up_vld (accept),
        .up_rdy (buf_rdy),
        .dn_dat (buf_out),
        .dn_vld (m_axis_tvalid),
        .dn_rdy (m_axis_tready),
        .empty  (buf_empty)
    );

    assign {m_axis_tdata, m_axis_tlast, m_axis_tuser} = buf_out;
    assign m_hs = m_axis_tvalid & m_axis_tready;

    // A clear on the same cycle as a handshake or truncation wins.
    always_ff @(posedge axi_aclk or posedge sys_rst) begin
        if (sys_rst) begin
            beat_cnt <= '0;
            trunc    <= 1'b0;
            ovf      <= 1'b0;
        end else if (clr_stats) begin
            beat_cnt <= '0;
            trunc    <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            if (m_hs) begin
                if (beat_cnt != CNT_TOP) begin
                    beat_cnt <= beat_cnt + 1'b1;
                end
                if (beat_cnt >= CNT_TOP - 1'b1) begin
                    ovf <= 1'b1;
                end
            end
            if (forced) begin
                trunc <= 1'b1;
            end
        end
    end

    always_comb begin
        gpio_out = '0;
        gpio_out[GPIO_CNT_LSB  +: GPIO_CNT_W]  = GPIO_CNT_W'(beat_cnt);
        gpio_out[GPIO_PEND_LSB +: GPIO_PEND_W] = GPIO_PEND_W'(s_axis_tvalid);
        gpio_out[GPIO_GNT_LSB  +: GPIO_GNT_W]  = GPIO_GNT_W'(grant_q);
        gpio_out[GPIO_BUSY_BIT]  = (state_q == ST_GRANT) | ~buf_empty;
        gpio_out[GPIO_TRUNC_BIT] = trunc;
        gpio_out[GPIO_OVF_BIT]   = ovf;
        gpio_out[GPIO_STALL_BIT] = m_axis_tvalid & ~m_axis_tready;
    end

endmodule

// File: tb/tb_sddt_cmd_arbiter.sv
// Scoreboarded bench for sddt_cmd_arbiter: per-channel beat drivers, expected-output queue, output monitor.
module tb_sddt_cmd_arbiter;

    localparam int NUM_CH    = 2;
    localparam int DATA_W    = 128;
    localparam int MAX_BURST = 16;
    localparam int CNT_W     = 16;
    localparam int CH_W      = 1;

    logic                     axi_aclk = 1'b0;
    logic                     sys_rst;
    logic [NUM_CH*DATA_W-1:0] s_axis_tdata;
    logic [NUM_CH-1:0]        s_axis_tvalid;
    logic [NUM_CH-1:0]        s_axis_tlast;
    logic [NUM_CH-1:0]        s_axis_tready;
    logic [DATA_W-1:0]        m_axis_tdata;
    logic                     m_axis_tvalid;
    logic                     m_axis_tlast;
    logic [CH_W-1:0]          m_axis_tuser;
    logic                     m_axis_tready;
    logic [NUM_CH-1:0]        ch_enable;
    logic                     clr_stats;
    logic [31:0]              gpio_out;

    sddt_cmd_arbiter #(
        .NUM_CH    (NUM_CH),
        .DATA_W    (DATA_W),
        .MAX_BURST (MAX_BURST),
        .CNT_W     (CNT_W)
    ) dut (
        .axi_aclk      (axi_aclk),
        .sys_rst       (sys_rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tready (m_axis_tready),
        .ch_enable     (ch_enable),
        .clr_stats     (clr_stats),
        .gpio_out      (gpio_out)
    );

    always #5 axi_aclk = ~axi_aclk;

    typedef struct packed {
        logic [DATA_W-1:0] dat;
        logic              last;
    } beat_t;

    typedef struct packed {
        logic [DATA_W-1:0] dat;
        logic              last;
        logic [CH_W-1:0]   ch;
    } out_t;

    beat_t q0[$];
    beat_t q1[$];
    out_t  exp_q[$];
    int    hs_cyc[$];
    int    n_chk  = 0;
    int    n_pass = 0;
    int    cyc    = 0;
    int    rdy_mode = 0;   // 0: ready held high, 1: toggle each cycle, 2: held low

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, req);
    endtask

    task automatic stim(input int ch, input logic [DATA_W-1:0] dat, input logic last);
        beat_t b;
        b.dat  = dat;
        b.last = last;
        if (ch == 0) q0.push_back(b);
        else q1.push_back(b);
    endtask

    task automatic expect_out(input int ch, input logic [DATA_W-1:0] dat, input logic last);
        out_t o;
        o.dat = dat;
`ifdef SDDT_CMD_CH_TAG_EN
        o.dat[DATA_W-1 -: 3] = 3'(ch);
`endif
        o.last = last;
        o.ch   = CH_W'(ch);
        exp_q.push_back(o);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int k = 0;
        do begin
            @(negedge axi_aclk);
            k++;
        end while ((exp_q.size() != 0 || gpio_out[27]) && k < budget);
        if (k >= budget) begin
            n_chk++;
            $display("FAIL %s_timeout: %0d beats outstanding after %0d cycles", name, exp_q.size(), k);
        end
    endtask

    task automatic pulse_clr();
        @(posedge axi_aclk); #1;
        clr_stats = 1'b1;
        @(posedge axi_aclk); #1;
        clr_stats = 1'b0;
        @(negedge axi_aclk);
    endtask

    initial forever begin
        @(posedge axi_aclk);
        cyc++;
    end

    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge axi_aclk); #1;
            case (rdy_mode)
                0:       m_axis_tready = 1'b1;
                1:       m_axis_tready = ~m_axis_tready;
                default: m_axis_tready = 1'b0;
            endcase
        end
    end

    // Channel drivers: a beat retires at the edge where tvalid&tready were both high.
    initial begin
        logic [1:0] hs;
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
        s_axis_tdata  = '0;
        forever begin
            @(negedge axi_aclk);
            hs = s_axis_tvalid & s_axis_tready;
            @(posedge axi_aclk); #1;
            if (hs[0] && q0.size() > 0) void'(q0.pop_front());
            if (hs[1] && q1.size() > 0) void'(q1.pop_front());
            if (q0.size() > 0) begin
                s_axis_tvalid[0]         = 1'b1;
                s_axis_tdata[0 +: DATA_W] = q0[0].dat;
                s_axis_tlast[0]          = q0[0].last;
            end else begin
                s_axis_tvalid[0] = 1'b0;
            end
            if (q1.size() > 0) begin
                s_axis_tvalid[1]              = 1'b1;
                s_axis_tdata[DATA_W +: DATA_W] = q1[0].dat;
                s_axis_tlast[1]               = q1[0].last;
            end else begin
                s_axis_tvalid[1] = 1'b0;
            end
        end
    end

    initial begin
        logic prev_stall;
        out_t prev_out;
        out_t got;
        out_t want;
        prev_stall = 1'b0;
        prev_out   = '0;
        forever begin
            @(negedge axi_aclk);
            got = {m_axis_tdata, m_axis_tlast, m_axis_tuser};
            if (sys_rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", m_axis_tvalid, 1'b1);
                    check("hold_data", got, prev_out);
                end
                if (m_axis_tvalid && !m_axis_tready) check("stall_flag", gpio_out[30], 1'b1);
                if (m_axis_tvalid && m_axis_tready) begin
                    hs_cyc.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        $display("FAIL unexpected_beat: got %0h, nothing expected", got);
                    end else begin
                        want = exp_q.pop_front();
                        check("beat", got, want);
                    end
                end
                prev_stall = m_axis_tvalid & ~m_axis_tready;
                prev_out   = got;
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        int g2[4];
        g2 = '{1, 1, 1, 2};
        sys_rst   = 1'b1;
        ch_enable = '1;
        clr_stats = 1'b0;
        repeat (3) @(negedge axi_aclk);
        check("rst_m_tvalid", m_axis_tvalid, 1'b0);
        check("rst_s_tready", s_axis_tready, 2'b00);
        check("rst_gpio", gpio_out, 32'h0);
        check("rst_tdata", m_axis_tdata, 128'h0);
        check("rst_tuser", {m_axis_tuser, m_axis_tlast}, 2'b00);
        @(posedge axi_aclk); #2;
        sys_rst = 1'b0;
        @(negedge axi_aclk);

        // Both channels hold single-beat commands; rr_ptr=0 so ch1 wins first, then strict alternation.
        hs_cyc.delete();
        for (int i = 0; i < 3; i++) begin
            stim(0, 128'hA000 + 128'(i), 1'b1);
            stim(1, 128'hB000 + 128'(i), 1'b1);
        end
        for (int i = 0; i < 3; i++) begin
            expect_out(1, 128'hB000 + 128'(i), 1'b1);
            expect_out(0, 128'hA000 + 128'(i), 1'b1);
        end
        wait_drain("t1", 200);
        check("t1_count", hs_cyc.size(), 6);
        for (int i = 0; i + 1 < hs_cyc.size(); i++) check("t1_gap", hs_cyc[i+1] - hs_cyc[i], 2);

        // 4-beat ch1 burst locks out a waiting ch0 until its tlast.
        hs_cyc.delete();
        for (int i = 0; i < 4; i++) stim(1, 128'hC100 + 128'(i), i == 3);
        stim(0, 128'hC000, 1'b1);
        for (int i = 0; i < 4; i++) expect_out(1, 128'hC100 + 128'(i), i == 3);
        expect_out(0, 128'hC000, 1'b1);
        wait_drain("t2", 200);
        check("t2_count", hs_cyc.size(), 5);
        for (int i = 0; i < 4; i++) if (i + 1 < hs_cyc.size()) check("t2_gap", hs_cyc[i+1] - hs_cyc[i], g2[i]);

        // A disabled channel stays pending but is never granted until re-enabled.
        ch_enable = 2'b01;
        stim(1, 128'hD100, 1'b1);
        stim(0, 128'hD000, 1'b1);
        stim(0, 128'hD001, 1'b1);
        expect_out(0, 128'hD000, 1'b1);
        expect_out(0, 128'hD001, 1'b1);
        wait_drain("t_en", 200);
        check("t_en_pending", gpio_out[23:16], 8'h02);
        ch_enable = 2'b11;
        expect_out(1, 128'hD100, 1'b1);
        wait_drain("t_en2", 200);

        // 20-beat burst: beat 16 gets a forced tlast, the rest follow after re-arbitration.
        for (int i = 0; i < 20; i++) begin
            stim(0, 128'hE000 + 128'(i), i == 19);
            expect_out(0, 128'hE000 + 128'(i), (i == 15) || (i == 19));
        end
        wait_drain("t3", 300);
        check("t3_trunc", gpio_out[28], 1'b1);
        check("t3_grant", gpio_out[26:24], 3'd0);
        pulse_clr();
        check("t3_clr_trunc", gpio_out[28], 1'b0);
        check("t3_clr_cnt", gpio_out[15:0], 16'h0);

        // Output ready toggling: order, hold and stall flag are checked by the monitor.
        rdy_mode = 1;
        for (int i = 0; i < 8; i++) begin
            stim(1, 128'hF100 + 128'(i), i == 7);
            expect_out(1, 128'hF100 + 128'(i), i == 7);
        end
        wait_drain("t4", 300);
        rdy_mode = 0;
        @(negedge axi_aclk);
        check("t4_cnt", gpio_out[15:0], 16'd8);

        // Counter saturation over 65540 handshakes, then clear.
        pulse_clr();
        for (int i = 0; i < 65540; i++) begin
            logic l;
            l = (i % 16 == 15) || (i == 65539);
            stim(0, 128'h5000_0000 + 128'(i), l);
            expect_out(0, 128'h5000_0000 + 128'(i), l);
        end
        wait_drain("t5", 80000);
        check("t5_cnt_sat", gpio_out[15:0], 16'hFFFF);
        check("t5_ovf", gpio_out[29], 1'b1);
        pulse_clr();
        check("t5_clr_cnt", gpio_out[15:0], 16'h0);
        check("t5_clr_ovf", gpio_out[29], 1'b0);

        // Reset in the middle of a stalled burst.
        rdy_mode = 2;
        repeat (2) @(negedge axi_aclk);
        for (int i = 0; i < 10; i++) begin
            stim(0, 128'h6000 + 128'(i), 1'b0);
            expect_out(0, 128'h6000 + 128'(i), 1'b0);
        end
        repeat (6) @(negedge axi_aclk);
        check("t6_busy", gpio_out[27], 1'b1);
        check("t6_pending", gpio_out[23:16], 8'h01);
        q0.delete();
        @(posedge axi_aclk); #3;
        sys_rst = 1'b1;
        exp_q.delete();
        #1;
        check("t6_m_tvalid", m_axis_tvalid, 1'b0);
        check("t6_s_tready", s_axis_tready, 2'b00);
        check("t6_gpio", gpio_out, 32'h0);
        repeat (2) @(posedge axi_aclk);
        #2;
        sys_rst  = 1'b0;
        rdy_mode = 0;
        @(negedge axi_aclk);
        stim(0, 128'h7000, 1'b1);
        stim(1, 128'h7100, 1'b1);
        expect_out(1, 128'h7100, 1'b1);
        expect_out(0, 128'h7000, 1'b1);
        wait_drain("t6", 200);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
